// File: rtl/ifetch_burst_unit.sv
// Instruction-fetch front end: line-aligned AXI read bursts unpacked into a PC-tagged instruction FIFO.
// IDLE: load entry PC | REQ: issue line read | DATA: push beats | DRAIN: discard stale burst | HALT: bus error, wait redirect
module ifetch_burst_unit #(
    parameter int ID_WIDTH    = 13,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_BEATS = 8,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] entry_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ID_WIDTH-1:0]   m_axi_arid_o,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
    output logic [7:0]            m_axi_arlen_o,
    output logic [2:0]            m_axi_arsize_o,
    output logic [1:0]            m_axi_arburst_o,
    output logic                  m_axi_arlock_o,
    output logic [3:0]            m_axi_arcache_o,
    output logic [2:0]            m_axi_arprot_o,
    output logic                  m_axi_arvalid_o,
    input  logic                  m_axi_arready_i,
    input  logic [ID_WIDTH-1:0]   m_axi_rid_i,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
    input  logic [1:0]            m_axi_rresp_i,
    input  logic                  m_axi_rlast_i,
    input  logic                  m_axi_rvalid_i,
    output logic                  m_axi_rready_o,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [31:0]           inst_data_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  inst_err_o
);
    localparam int IPB        = DATA_WIDTH / 32;
    localparam int LINE_INSTR = BURST_BEATS * IPB;
    localparam int LINE_BYTES = LINE_INSTR * 4;
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int DROP_W     = $clog2(IPB + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_DRAIN, S_HALT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]   tgt_q, tgt_d;
    logic                    first_q, first_d;
    logic                    stale_q, stale_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   ar_addr_q;
    logic [ADDR_WIDTH-1:0]   beat_addr_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [ADDR_WIDTH-1:0]   pc_mem   [FIFO_DEPTH];
    logic [31:0]             data_mem [FIFO_DEPTH];
    logic                    err_mem  [FIFO_DEPTH];

    logic                    ar_hs, r_hs, beat_err, beat_push, pop;
    logic [CNT_W-1:0]        free_cnt, n_push;
    logic [ADDR_WIDTH-1:0]   beat_pc [IPB];
    logic [IPB-1:0]          keep;
    logic [DROP_W-1:0]       n_drop;
    logic                    unused_rid;

    assign unused_rid = ^m_axi_rid_i;

    assign m_axi_arid_o    = '0;
    assign m_axi_arlen_o   = 8'(BURST_BEATS - 1);
    assign m_axi_arsize_o  = 3'($clog2(BEAT_BYTES));
    assign m_axi_arburst_o = 2'b01;
    assign m_axi_arlock_o  = 1'b0;
    assign m_axi_arcache_o = 4'b0011;
    assign m_axi_arprot_o  = 3'b100;
    assign m_axi_araddr_o  = ar_addr_q;

    // Space for a whole line is reserved before issue, so rready can stay high in DATA.
    assign free_cnt        = CNT_W'(FIFO_DEPTH) - count_q;
    assign m_axi_arvalid_o = (state_q == S_REQ) && (stale_q || (free_cnt >= CNT_W'(LINE_INSTR)));
    assign m_axi_rready_o  = (state_q == S_DATA) || (state_q == S_DRAIN);

    assign ar_hs     = m_axi_arvalid_o && m_axi_arready_i;
    assign r_hs      = m_axi_rvalid_i && m_axi_rready_o;
    assign beat_err  = (m_axi_rresp_i != 2'b00);
    assign beat_push = (state_q == S_DATA) && r_hs && !redirect_valid_i;
    assign pop       = inst_valid_o && inst_ready_i && !redirect_valid_i;

    assign inst_valid_o = (count_q != '0);
    assign inst_data_o  = data_mem[rd_ptr_q];
    assign inst_pc_o    = pc_mem[rd_ptr_q];
    assign inst_err_o   = inst_valid_o && err_mem[rd_ptr_q];

    // Dropped instructions always form a prefix of the beat, so kept ones pack down by n_drop.
    always_comb begin
        keep   = '0;
        n_drop = '0;
        for (int k = 0; k < IPB; k++) begin
            beat_pc[k] = beat_addr_q + ADDR_WIDTH'(4 * k);
            keep[k]    = !first_q || (beat_pc[k] >= tgt_q);
            if (!keep[k]) n_drop = n_drop + DROP_W'(1);
        end
        n_push  = beat_push ? (CNT_W'(IPB) - CNT_W'(n_drop)) : '0;
        count_d = redirect_valid_i ? '0 : (count_q + n_push - CNT_W'(pop));
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        tgt_d      = tgt_q;
        first_d    = first_q;
        stale_d    = stale_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                fetch_pc_d = entry_i;
                tgt_d      = entry_i;
                first_d    = 1'b1;
                state_d    = S_REQ;
            end
            S_REQ: begin
                if (ar_hs) begin
                    state_d = stale_q ? S_DRAIN : S_DATA;
                    stale_d = 1'b0;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    if (beat_err) err_d = 1'b1;
                    if (m_axi_rlast_i) begin
                        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(LINE_BYTES);
                        first_d    = 1'b0;
                        err_d      = 1'b0;
                        state_d    = (err_q || beat_err) ? S_HALT : S_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (r_hs && m_axi_rlast_i) state_d = S_REQ;
            end
            default: ;
        endcase
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            tgt_d      = redirect_pc_i;
            first_d    = 1'b1;
            err_d      = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (ar_hs) state_d = S_DRAIN;
                    else if (m_axi_arvalid_o) stale_d = 1'b1;
                end
                S_DATA, S_DRAIN: state_d = (r_hs && m_axi_rlast_i) ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= '0;
            tgt_q       <= '0;
            first_q     <= 1'b0;
            stale_q     <= 1'b0;
            err_q       <= 1'b0;
            ar_addr_q   <= '0;
            beat_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            tgt_q      <= tgt_d;
            first_q    <= first_d;
            stale_q    <= stale_d;
            err_q      <= err_d;
            count_q    <= count_d;
            if (!(m_axi_arvalid_o && !m_axi_arready_i))
                ar_addr_q <= fetch_pc_d & ~ADDR_WIDTH'(LINE_BYTES - 1);
            if (ar_hs) beat_addr_q <= m_axi_araddr_o;
            else if (r_hs) beat_addr_q <= beat_addr_q + ADDR_WIDTH'(BEAT_BYTES);
            if (redirect_valid_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
                if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (beat_push) begin
            for (int k = 0; k < IPB; k++) begin
                if (keep[k]) begin
                    pc_mem[wr_ptr_q + PTR_W'(k) - PTR_W'(n_drop)]   <= beat_pc[k];
                    data_mem[wr_ptr_q + PTR_W'(k) - PTR_W'(n_drop)] <= m_axi_rdata_i[32*k +: 32];
                    err_mem[wr_ptr_q + PTR_W'(k) - PTR_W'(n_drop)]  <= beat_err;
                end
            end
        end
    end
endmodule

// File: tb/tb_ifetch_burst_unit.sv
// Directed bench for ifetch_burst_unit: bench-side AXI read slave and decode sink with fixed expected streams.
module tb_ifetch_burst_unit;
    localparam int ID_WIDTH    = 13;
    localparam int ADDR_WIDTH  = 64;
    localparam int DATA_WIDTH  = 64;
    localparam int BURST_BEATS = 8;
    localparam int FIFO_DEPTH  = 32;
    localparam int IPB         = DATA_WIDTH / 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [ADDR_WIDTH-1:0] entry;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [31:0]           inst_data;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  inst_err;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] q_pc[$];
    logic [31:0] q_data[$];
    logic        q_err[$];

    always #5 clk = ~clk;

    ifetch_burst_unit #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .BURST_BEATS(BURST_BEATS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk), .reset_i(reset), .entry_i(entry),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .m_axi_arid_o(arid), .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen),
        .m_axi_arsize_o(arsize), .m_axi_arburst_o(arburst), .m_axi_arlock_o(arlock),
        .m_axi_arcache_o(arcache), .m_axi_arprot_o(arprot),
        .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_rid_i(rid), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp),
        .m_axi_rlast_i(rlast), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
        .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_data_o(inst_data),
        .inst_pc_o(inst_pc), .inst_err_o(inst_err)
    );

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return 32'hC0DE_0000 ^ pc[31:0];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decode sink: a pop happens at the next rising edge unless a redirect is present.
    always @(negedge clk) begin
        if (!reset && inst_valid && inst_ready && !redirect_valid) begin
            q_pc.push_back(inst_pc);
            q_data.push_back(inst_data);
            q_err.push_back(inst_err);
        end
    end

    task automatic do_reset(input logic [63:0] entry_v);
        reset = 1'b1; arready = 1'b1; inst_ready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        rdata = '0; rresp = 2'b00; rid = '0; redirect_valid = 1'b0; redirect_pc = '0;
        entry = entry_v;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_rready", rready, 0);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_inst_err", inst_err, 0);
        check_eq("rst_araddr", araddr, 0);
        q_pc.delete(); q_data.delete(); q_err.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("idle_arvalid", arvalid, 0);
    endtask

    // Expects arready already high: checks the address seen just before the handshake edge.
    task automatic wait_ar(input string tag, input logic [63:0] exp_addr, output int waited);
        waited = 0;
        @(negedge clk);
        while (!arvalid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_arvalid"}, arvalid, 1);
        check_eq({tag, "_araddr"}, araddr, exp_addr);
        @(posedge clk); #1;
    endtask

    task automatic send_line(input logic [63:0] base, input int err_beat, input int redir_beat,
                             input logic [63:0] redir_to);
        int n;
        for (int b = 0; b < BURST_BEATS; b++) begin
            for (int k = 0; k < IPB; k++) rdata[32*k +: 32] = instr_of(base + 64'(8*b + 4*k));
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            rlast  = (b == BURST_BEATS - 1);
            rvalid = 1'b1;
            if (b == redir_beat) begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_to;
            end
            n = 0;
            @(negedge clk);
            while (!rready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check_eq("beat_rready", rready, 1);
            @(posedge clk); #1;
            if (b == redir_beat) begin
                redirect_valid = 1'b0;
                check_eq("redir_flush", inst_valid, 0);
            end
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic check_stream(input string tag, input logic [63:0] first_pc, input int n,
                                input logic [63:0] err_lo, input logic [63:0] err_hi);
        int c = 0;
        logic [63:0] pc;
        while (q_pc.size() < n && c < 300) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
        check_eq({tag, "_count"}, q_pc.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < q_pc.size()) begin
                pc = first_pc + 64'(4*i);
                check_eq({tag, "_pc"}, q_pc[i], pc);
                check_eq({tag, "_data"}, q_data[i], instr_of(pc));
                check_eq({tag, "_err"}, q_err[i], (pc >= err_lo && pc <= err_hi));
            end
        end
        q_pc.delete(); q_data.delete(); q_err.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int ar_seen;

        // Basic line from 0x1000, AR fields, first request latency, next line address
        do_reset(64'h1000);
        inst_ready = 1'b1;
        wait_ar("t1", 64'h1000, w);
        check_eq("t1_first_ar_latency", w, 0);
        check_eq("t1_arlen", arlen, 7);
        check_eq("t1_arsize", arsize, 3);
        check_eq("t1_arburst", arburst, 1);
        check_eq("t1_arid", arid, 0);
        check_eq("t1_arlock", arlock, 0);
        check_eq("t1_arcache", arcache, 4'b0011);
        check_eq("t1_arprot", arprot, 3'b100);
        send_line(64'h1000, -1, -1, 64'h0);
        wait_ar("t1_next", 64'h1040, w);
        check_stream("t1", 64'h1000, 16, 64'h1, 64'h0);

        // Mid-line entry: instructions before the target are dropped
        do_reset(64'h1014);
        inst_ready = 1'b1;
        wait_ar("t2", 64'h1000, w);
        send_line(64'h1000, -1, -1, 64'h0);
        check_stream("t2", 64'h1014, 11, 64'h1, 64'h0);

        // Backpressure: two lines fill the FIFO, third request waits for 16 pops
        do_reset(64'h1000);
        wait_ar("t3_l0", 64'h1000, w);
        check_eq("t3_empty_before", inst_valid, 0);
        send_line(64'h1000, -1, -1, 64'h0);
        check_eq("t3_valid_after", inst_valid, 1);
        wait_ar("t3_l1", 64'h1040, w);
        send_line(64'h1040, -1, -1, 64'h0);
        ar_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (arvalid) ar_seen++;
        end
        check_eq("t3_no_third_ar", ar_seen, 0);
        @(posedge clk); #1 inst_ready = 1'b1;
        repeat (16) @(posedge clk);
        #1 inst_ready = 1'b0;
        wait_ar("t3_l2", 64'h1080, w);
        check_stream("t3", 64'h1000, 16, 64'h1, 64'h0);

        // Redirect during a burst: remainder drained, new line fetched from target
        do_reset(64'h1000);
        wait_ar("t4", 64'h1000, w);
        send_line(64'h1000, -1, 3, 64'h2008);
        check_eq("t4_drained_valid", inst_valid, 0);
        wait_ar("t4_new", 64'h2000, w);
        send_line(64'h2000, -1, -1, 64'h0);
        inst_ready = 1'b1;
        check_stream("t4", 64'h2008, 14, 64'h1, 64'h0);

        // Redirect while a request is pending: address held, burst drained
        do_reset(64'h1000);
        arready = 1'b0;
        inst_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (!arvalid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("t5_pending_ar", arvalid, 1);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        @(posedge clk); #1 redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t5_hold_arvalid", arvalid, 1);
            check_eq("t5_hold_araddr", araddr, 64'h1000);
            @(posedge clk); #1;
        end
        arready = 1'b1;
        wait_ar("t5_old", 64'h1000, w);
        send_line(64'h1000, -1, -1, 64'h0);
        check_eq("t5_drain_valid", inst_valid, 0);
        check_eq("t5_drain_pops", q_pc.size(), 0);
        wait_ar("t5_new", 64'h4000, w);
        send_line(64'h4000, -1, -1, 64'h0);
        check_stream("t5", 64'h4000, 16, 64'h1, 64'h0);

        // Bus error on the fifth beat: flagged instructions, halt, redirect resumes
        do_reset(64'h1000);
        inst_ready = 1'b1;
        wait_ar("t6", 64'h1000, w);
        send_line(64'h1000, 4, -1, 64'h0);
        check_stream("t6", 64'h1000, 16, 64'h1020, 64'h1024);
        ar_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (arvalid) ar_seen++;
        end
        check_eq("t6_halt_no_ar", ar_seen, 0);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_ar("t6_resume", 64'h3000, w);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
